// File: rtl/toyrisc_mc_if.sv
// toyrisc_mc_if: instruction fetch, data memory handshake and status bundle for the toyRISC multi-cycle core
interface toyrisc_mc_if #(
    parameter int DW = 32,
    parameter int PC_W = 16
);
    logic [PC_W-1:0] instrAddr;
    logic [31:0]     instruction;
    logic [DW-1:0]   dataAddr;
    logic [DW-1:0]   dataOut;
    logic [DW-1:0]   dataIn;
    logic            we;
    logic            dataReq;
    logic            dataAck;
    logic            halted;

    modport master (
        output instrAddr, dataAddr, dataOut, we, dataReq, halted,
        input  instruction, dataIn, dataAck
    );

    modport slave (
        input  instrAddr, dataAddr, dataOut, we, dataReq, halted,
        output instruction, dataIn, dataAck
    );
endinterface

// File: rtl/toyrisc_mc.sv
// toyrisc_mc: multi-cycle toyRISC core with one-cycle ALU/branch execution and stalling req/ack loads and stores
module toyrisc_mc #(
    parameter int DW = 32,
    parameter int PC_W = 16,
    parameter int REG_AW = 4
) (
    input logic clock,
    input logic reset,
    toyrisc_mc_if.master bus
);
    typedef enum logic [1:0] {RUN, MEM, HALTED} state_t;

    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [DW-1:0]     regs [2**REG_AW];
    logic [REG_AW-1:0] memRd;
    logic [DW-1:0]     dataAddrQ;
    logic [DW-1:0]     dataOutQ;
    logic              reqQ;
    logic              weQ;
    logic              haltedQ;

    logic [5:0]        op;
    logic [REG_AW-1:0] rdIdx;
    logic [REG_AW-1:0] rsIdx;
    logic [REG_AW-1:0] rtIdx;
    logic [15:0]       imm;
    logic [DW-1:0]     rsVal;
    logic [DW-1:0]     rtVal;
    logic [DW-1:0]     result;
    logic              writeEn;
    logic [PC_W-1:0]   target;
    logic [PC_W-1:0]   pcInc;
    logic [PC_W-1:0]   nextPc;
    logic              isMem;
    logic              isHalt;
    logic              unusedBits;

    assign bus.instrAddr = pc;
    assign bus.dataAddr  = dataAddrQ;
    assign bus.dataOut   = dataOutQ;
    assign bus.dataReq   = reqQ;
    assign bus.we        = weQ;
    assign bus.halted    = haltedQ;
    assign unusedBits    = ^bus.instruction;

    // Decode the fetched word and compute the register result and next pc for RUN
    always_comb begin
        op      = bus.instruction[31:26];
        rdIdx   = bus.instruction[21 +: REG_AW];
        rsIdx   = bus.instruction[16 +: REG_AW];
        rtIdx   = bus.instruction[11 +: REG_AW];
        imm     = bus.instruction[15:0];
        rsVal   = regs[rsIdx];
        rtVal   = regs[rtIdx];
        target  = PC_W'(imm);
        pcInc   = pc + PC_W'(1);
        isMem   = (op == 6'h10) || (op == 6'h11);
        isHalt  = (op == 6'h3F);
        result  = '0;
        writeEn = 1'b0;
        nextPc  = pcInc;
        case (op)
            6'h01: begin result = rsVal + rtVal; writeEn = 1'b1; end
            6'h02: begin result = rsVal - rtVal; writeEn = 1'b1; end
            6'h03: begin result = rsVal & rtVal; writeEn = 1'b1; end
            6'h04: begin result = rsVal | rtVal; writeEn = 1'b1; end
            6'h05: begin result = rsVal ^ rtVal; writeEn = 1'b1; end
            6'h08: begin result = rsVal + DW'($signed(imm)); writeEn = 1'b1; end
            6'h09: begin result = DW'(imm); writeEn = 1'b1; end
            6'h20: nextPc = target;
            6'h21: nextPc = (rsVal == '0) ? target : pcInc;
            6'h22: nextPc = (rsVal != '0) ? target : pcInc;
            default: ;
        endcase
    end

    // Core state machine: execute in RUN, hold the bus through MEM wait states, freeze in HALTED
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RUN;
            pc        <= '0;
            memRd     <= '0;
            dataAddrQ <= '0;
            dataOutQ  <= '0;
            reqQ      <= 1'b0;
            weQ       <= 1'b0;
            haltedQ   <= 1'b0;
            for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (writeEn) regs[rdIdx] <= result;
                    if (isMem) begin
                        memRd     <= rdIdx;
                        dataAddrQ <= rsVal;
                        dataOutQ  <= rtVal;
                        reqQ      <= 1'b1;
                        weQ       <= (op == 6'h11);
                        state     <= MEM;
                    end else if (isHalt) begin
                        haltedQ <= 1'b1;
                        state   <= HALTED;
                    end else begin
                        pc <= nextPc;
                    end
                end
                MEM: begin
                    if (bus.dataAck) begin
                        if (!weQ) regs[memRd] <= bus.dataIn;
                        pc    <= pcInc;
                        reqQ  <= 1'b0;
                        weQ   <= 1'b0;
                        state <= RUN;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_toyrisc_mc.sv
// tb_toyrisc_mc: directed programs with a store scoreboard checked by the memory-side monitor
module tb_toyrisc_mc;
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    toyrisc_mc_if #(.DW(32), .PC_W(16)) bus();

    toyrisc_mc #(.DW(32), .PC_W(16), .REG_AW(4)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } store_t;

    logic [31:0] imem [0:65535];
    store_t      expQ[$];
    store_t      expS;
    int          checks = 0;
    int          failures = 0;
    int          ackDelay = 0;
    int          waitCnt = 0;

    localparam logic [31:0] HALT = {6'h3F, 26'h0};
    localparam logic [31:0] NOP  = 32'h0;

    assign bus.instruction = imem[bus.instrAddr];

    // Memory responder acks after ackDelay wait cycles, then the monitor scores each completed store
    always @(negedge clock) begin
        if (bus.dataReq) begin
            bus.dataAck = (waitCnt == ackDelay);
            waitCnt++;
        end else begin
            bus.dataAck = 1'b0;
            waitCnt = 0;
        end
        if (bus.dataReq && bus.we && bus.dataAck) begin
            checks++;
            if (expQ.size() == 0) begin
                failures++;
                $display("FAIL store_unexpected: got addr=%h data=%h, expected no store", bus.dataAddr, bus.dataOut);
            end else begin
                expS = expQ.pop_front();
                if (bus.dataAddr !== expS.addr || bus.dataOut !== expS.data) begin
                    failures++;
                    $display("FAIL store: got addr=%h data=%h, expected addr=%h data=%h",
                             bus.dataAddr, bus.dataOut, expS.addr, expS.data);
                end
            end
        end
    end

    // Watchdog so the bench always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
        return {op, 5'(rd), 5'(rs), 5'(rt), 11'b0};
    endfunction

    function automatic logic [31:0] ri(input logic [5:0] op, input int rd, input int rs, input logic [15:0] imm);
        return {op, 5'(rd), 5'(rs), imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic clearMem();
        for (int i = 0; i < 65536; i++) imem[i] = NOP;
    endtask

    task automatic pushStore(input logic [31:0] addr, input logic [31:0] data);
        expQ.push_back({addr, data});
    endtask

    task automatic doReset();
        reset = 1'b1;
        bus.dataIn = $urandom;
        repeat (2) step();
        reset = 1'b0;
        check("rst_instrAddr", 32'(bus.instrAddr), 32'h0);
        check("rst_dataReq", 32'(bus.dataReq), 32'h0);
        check("rst_we", 32'(bus.we), 32'h0);
        check("rst_halted", 32'(bus.halted), 32'h0);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && expQ.size() != 0; i++) step();
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d stores outstanding, expected 0", expQ.size());
            expQ.delete();
        end
    endtask

    initial begin
        logic [15:0] pcSeq [8];
        bus.dataIn = 32'h0;
        clearMem();
        ackDelay = 0;
        for (int i = 1; i < 16; i++) imem[i-1] = ri(6'h09, i, 0, 16'(16'h0100 + i));
        imem[15] = HALT;
        doReset();
        repeat (20) step();
        check("dirty_halted", 32'(bus.halted), 32'h1);

        clearMem();
        for (int i = 1; i < 16; i++) begin
            imem[i-1] = rr(6'h11, 0, 0, i);
            pushStore(32'h0, 32'h0);
        end
        imem[15] = HALT;
        doReset();
        drain(200);

        clearMem();
        imem[0]  = ri(6'h09, 1, 0, 16'h0005);
        imem[1]  = ri(6'h09, 2, 0, 16'hFFFF);
        imem[2]  = rr(6'h01, 3, 1, 2);
        imem[3]  = rr(6'h02, 4, 1, 2);
        imem[4]  = ri(6'h08, 5, 1, 16'hFFFF);
        imem[5]  = ri(6'h09, 6, 0, 16'h0001);
        imem[6]  = ri(6'h09, 7, 0, 16'h0002);
        imem[7]  = ri(6'h09, 9, 0, 16'h0003);
        imem[8]  = rr(6'h01, 1, 1, 1);
        imem[9]  = rr(6'h11, 0, 0, 3);
        imem[10] = rr(6'h11, 0, 6, 4);
        imem[11] = rr(6'h11, 0, 7, 5);
        imem[12] = rr(6'h11, 0, 9, 1);
        imem[13] = rr(6'h05, 10, 2, 1);
        imem[14] = rr(6'h03, 11, 2, 4);
        imem[15] = rr(6'h04, 12, 1, 4);
        imem[16] = rr(6'h11, 0, 0, 10);
        imem[17] = rr(6'h11, 0, 0, 11);
        imem[18] = rr(6'h11, 0, 0, 12);
        imem[19] = rr(6'h3E, 1, 1, 1);
        imem[20] = rr(6'h11, 0, 9, 1);
        imem[21] = HALT;
        pushStore(32'h0, 32'h00010004);
        pushStore(32'h1, 32'hFFFF0006);
        pushStore(32'h2, 32'h00000004);
        pushStore(32'h3, 32'h0000000A);
        pushStore(32'h0, 32'h0000FFF5);
        pushStore(32'h0, 32'h00000006);
        pushStore(32'h0, 32'hFFFF000E);
        pushStore(32'h3, 32'h0000000A);
        doReset();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("alu_pc%0d", k), 32'(bus.instrAddr), 32'(k));
            step();
        end
        drain(200);
        repeat (3) step();
        check("alu_halted", 32'(bus.halted), 32'h1);

        clearMem();
        ackDelay = 3;
        imem[0] = ri(6'h09, 1, 0, 16'h0010);
        imem[1] = ri(6'h09, 2, 0, 16'h00AB);
        imem[2] = rr(6'h11, 0, 1, 2);
        imem[3] = NOP;
        imem[4] = HALT;
        pushStore(32'h10, 32'hAB);
        doReset();
        repeat (3) step();
        for (int m = 0; m < 4; m++) begin
            check($sformatf("st_req%0d", m), 32'(bus.dataReq), 32'h1);
            check($sformatf("st_we%0d", m), 32'(bus.we), 32'h1);
            check($sformatf("st_addr%0d", m), bus.dataAddr, 32'h10);
            check($sformatf("st_data%0d", m), bus.dataOut, 32'hAB);
            check($sformatf("st_pc%0d", m), 32'(bus.instrAddr), 32'h2);
            step();
        end
        check("st_req_done", 32'(bus.dataReq), 32'h0);
        check("st_pc_next", 32'(bus.instrAddr), 32'h3);
        drain(20);

        clearMem();
        ackDelay = 0;
        imem[0] = ri(6'h09, 3, 0, 16'h0020);
        imem[1] = rr(6'h10, 3, 3, 0);
        imem[2] = rr(6'h11, 0, 0, 3);
        imem[3] = HALT;
        pushStore(32'h0, 32'hDEADBEEF);
        doReset();
        bus.dataIn = 32'hDEADBEEF;
        step();
        check("ld_pc", 32'(bus.instrAddr), 32'h1);
        step();
        check("ld_req", 32'(bus.dataReq), 32'h1);
        check("ld_we", 32'(bus.we), 32'h0);
        check("ld_addr", bus.dataAddr, 32'h20);
        step();
        check("ld_req_done", 32'(bus.dataReq), 32'h0);
        check("ld_we_done", 32'(bus.we), 32'h0);
        check("ld_pc_next", 32'(bus.instrAddr), 32'h2);
        drain(20);

        clearMem();
        imem[0]       = ri(6'h09, 2, 0, 16'h0001);
        imem[1]       = ri(6'h21, 0, 0, 16'h0100);
        imem[16'h100] = ri(6'h22, 0, 0, 16'h0200);
        imem[16'h101] = ri(6'h21, 0, 2, 16'h0300);
        imem[16'h102] = ri(6'h22, 0, 2, 16'h0400);
        imem[16'h400] = ri(6'h20, 0, 0, 16'hFFFF);
        imem[16'hFFFF] = NOP;
        pcSeq = '{16'h0000, 16'h0001, 16'h0100, 16'h0101, 16'h0102, 16'h0400, 16'hFFFF, 16'h0000};
        doReset();
        for (int k = 0; k < 8; k++) begin
            check($sformatf("br_pc%0d", k), 32'(bus.instrAddr), 32'(pcSeq[k]));
            step();
        end

        clearMem();
        imem[0] = ri(6'h09, 1, 0, 16'h0007);
        imem[1] = HALT;
        doReset();
        step();
        check("halt_pre", 32'(bus.halted), 32'h0);
        step();
        for (int k = 0; k < 10; k++) begin
            check($sformatf("halt_flag%0d", k), 32'(bus.halted), 32'h1);
            check($sformatf("halt_pc%0d", k), 32'(bus.instrAddr), 32'h1);
            check($sformatf("halt_req%0d", k), 32'(bus.dataReq), 32'h0);
            step();
        end

        clearMem();
        ackDelay = 1;
        imem[0] = ri(6'h09, 5, 0, 16'h0055);
        imem[1] = ri(6'h09, 6, 0, 16'h0030);
        imem[2] = rr(6'h10, 5, 6, 0);
        imem[3] = HALT;
        doReset();
        bus.dataIn = 32'hCAFEF00D;
        repeat (3) step();
        check("abort_req", 32'(bus.dataReq), 32'h1);
        check("abort_addr", bus.dataAddr, 32'h30);
        step();
        reset = 1'b1;
        imem[0] = rr(6'h11, 0, 0, 5);
        imem[1] = HALT;
        imem[2] = NOP;
        imem[3] = NOP;
        step();
        check("abort_req_off", 32'(bus.dataReq), 32'h0);
        check("abort_we_off", 32'(bus.we), 32'h0);
        check("abort_pc", 32'(bus.instrAddr), 32'h0);
        step();
        reset = 1'b0;
        pushStore(32'h0, 32'h0);
        drain(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
